mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D unified-memory arbiter.
// State, owner and latency-counter definitions used by the arbiter files.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int CNT_W = 4;

  // Streak counter must hold 0..max inclusive.
  function automatic int streak_w(input int max_dstreak);
    return $clog2(max_dstreak + 2);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch (I) and data (D) requesters.
// D normally wins; I is forced once D has won max_dstreak times in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = 2,
  parameter int SW          = 2
) (
  input  logic          d_req,
  input  logic          i_req,
  input  logic [SW-1:0] streak,
  output logic          grant_valid,
  output logic          owner
);

  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

  logic force_i;

  assign force_i     = i_req & (streak == SMAX);
  assign grant_valid = d_req | i_req;

  always_comb begin
    owner = OWN_D;
    priority case (1'b1)
      d_req && !force_i: owner = OWN_D;
      i_req:             owner = OWN_I;
      default:           owner = OWN_D;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one fixed-latency
// memory port: IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP -> IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam int SW = streak_w(MAX_DSTREAK);

  localparam logic [SW-1:0]    SMAX = SW'(MAX_DSTREAK);
  localparam logic [CNT_W-1:0] LAT  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic             owner;
  logic             is_store;
  logic [SW-1:0]    streak;
  logic [CNT_W-1:0] cnt;
  logic             gnt;
  logic             gnt_own;
  logic             take;
  logic             last_wait;

  mem_arb_pick #(
    .MAX_DSTREAK (MAX_DSTREAK),
    .SW          (SW)
  ) u_pick (
    .d_req       (d_req),
    .i_req       (i_req),
    .streak      (streak),
    .grant_valid (gnt),
    .owner       (gnt_own)
  );

  assign take      = (state == IDLE) & gnt;
  assign last_wait = (state == WAIT) & (cnt == ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cnt == ONE) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_D;
      is_store  <= 1'b0;
      streak    <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (take) begin
        owner <= gnt_own;
        if (gnt_own == OWN_D) begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          is_store  <= d_we;
        end else begin
          mem_addr  <= i_addr;
          is_store  <= 1'b0;
        end
        // Only D wins that starve a waiting fetch count toward the limit.
        if (gnt_own == OWN_D && i_req) begin
          if (streak != SMAX) streak <= streak + 1'b1;
        end else begin
          streak <= '0;
        end
      end
      if (state == ISSUE)     cnt <= LAT;
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (last_wait && !is_store) begin
        if (owner == OWN_D) d_rdata <= mem_rdata;
        else                i_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & is_store;
  assign i_ack     = (state == RESP) & (owner == OWN_I);
  assign d_ack     = (state == RESP) & (owner == OWN_D);
  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=2 main instance plus a
// MEM_LAT=1 instance, each backed by a small pipelined memory model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic          i_req = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] i_addr = 0, d_addr = 0;
  logic [DW-1:0] d_wdata = 0;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          i_ack, d_ack, mem_en, mem_we, stall_if, stall_mem;

  logic          b_i_req = 0, b_d_req = 0, b_d_we = 0;
  logic [AW-1:0] b_i_addr = 0, b_d_addr = 0;
  logic [DW-1:0] b_d_wdata = 0;
  logic [DW-1:0] b_i_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic          b_i_ack, b_d_ack, b_mem_en, b_mem_we;
  logic          b_stall_if, b_stall_mem;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .MAX_DSTREAK(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_DSTREAK(2)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .stall_if(b_stall_if), .stall_mem(b_stall_mem)
  );

  // Memory models: data is only valid exactly MEM_LAT cycles after mem_en.
  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];
  logic          bk_we = 0;
  logic [7:0]    bk_idx = 0;
  logic [DW-1:0] bk_data = 0;
  logic          pa_v1 = 0, pa_v2 = 0, pb_v1 = 0;
  logic [DW-1:0] pa_d1 = 0, pa_d2 = 0, pb_d1 = 0;

  always @(posedge clk) begin
    if (bk_we) begin
      mem_a[bk_idx] <= bk_data;
      mem_b[bk_idx] <= bk_data;
    end else begin
      if (mem_en && mem_we) mem_a[mem_addr[9:2]] <= mem_wdata;
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
    end
    pa_v1 <= mem_en & ~mem_we;
    pa_d1 <= mem_a[mem_addr[9:2]];
    pa_v2 <= pa_v1;
    pa_d2 <= pa_d1;
    pb_v1 <= b_mem_en & ~b_mem_we;
    pb_d1 <= mem_b[b_mem_addr[9:2]];
  end

  assign mem_rdata   = pa_v2 ? pa_d2 : 32'hBAD0_BAD0;
  assign b_mem_rdata = pb_v1 ? pb_d1 : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (int'(mem_en) + int'(i_ack) + int'(d_ack) > 1) begin
        failures++;
        $display("FAIL exclusive en=%b ia=%b da=%b req<=1", mem_en, i_ack, d_ack);
      end
      checks++;
      if (int'(b_mem_en) + int'(b_i_ack) + int'(b_d_ack) > 1) begin
        failures++;
        $display("FAIL exclusive_b en=%b ia=%b da=%b", b_mem_en, b_i_ack, b_d_ack);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] idx, input logic [DW-1:0] data);
    bk_idx  = idx;
    bk_data = data;
    bk_we   = 1'b1;
    tick();
    bk_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, i_ack, d_ack} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {mem_en, mem_we, i_ack, d_ack});
    end
    checks++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data addr=%h wd=%h ir=%h dr=%h exp=0",
               mem_addr, mem_wdata, i_rdata, d_rdata);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    poke(8'h04, 32'hDEAD_BEEF);
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin i_req = 1; i_addr = 32'h10; end
      if (c == 5) i_req = 0;
      @(negedge clk);
      checks++;
      if (mem_en !== (c == 1)) begin
        failures++;
        $display("FAIL fetch_en c=%0d got=%b exp=%b", c, mem_en, (c == 1));
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 32'h10) begin
          failures++;
          $display("FAIL fetch_addr got=%h exp=00000010", mem_addr);
        end
      end
      checks++;
      if (i_ack !== (c == 4)) begin
        failures++;
        $display("FAIL fetch_ack c=%0d got=%b exp=%b", c, i_ack, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (i_rdata !== 32'hDEAD_BEEF) begin
          failures++;
          $display("FAIL fetch_data got=%h exp=deadbeef", i_rdata);
        end
      end
      checks++;
      if (stall_if !== (c <= 3)) begin
        failures++;
        $display("FAIL fetch_stall c=%0d got=%b exp=%b", c, stall_if, (c <= 3));
      end
      tick();
    end
  endtask

  task automatic test_contention();
    poke(8'h10, 32'h1111_0040);
    poke(8'h08, 32'h2222_0020);
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) begin
        i_req = 1; i_addr = 32'h20;
        d_req = 1; d_we = 0; d_addr = 32'h40;
      end
      if (c == 5) d_req = 0;
      if (c == 10) i_req = 0;
      @(negedge clk);
      checks++;
      if (mem_en !== (c == 1 || c == 6)) begin
        failures++;
        $display("FAIL cont_en c=%0d got=%b", c, mem_en);
      end
      if (c == 1 || c == 6) begin
        checks++;
        if (mem_addr !== ((c == 1) ? 32'h40 : 32'h20)) begin
          failures++;
          $display("FAIL cont_addr c=%0d got=%h", c, mem_addr);
        end
      end
      checks++;
      if (d_ack !== (c == 4) || i_ack !== (c == 9)) begin
        failures++;
        $display("FAIL cont_ack c=%0d d=%b i=%b exp d=%b i=%b",
                 c, d_ack, i_ack, (c == 4), (c == 9));
      end
      if (c == 4) begin
        checks++;
        if (d_rdata !== 32'h1111_0040) begin
          failures++;
          $display("FAIL cont_ddata got=%h exp=11110040", d_rdata);
        end
      end
      if (c == 9) begin
        checks++;
        if (i_rdata !== 32'h2222_0020) begin
          failures++;
          $display("FAIL cont_idata got=%h exp=22220020", i_rdata);
        end
      end
      checks++;
      if (stall_mem !== (c <= 3) || stall_if !== (c <= 8)) begin
        failures++;
        $display("FAIL cont_stall c=%0d mem=%b if=%b", c, stall_mem, stall_if);
      end
      tick();
    end
  endtask

  task automatic test_streak();
    int  k;
    bit  done;
    logic [AW-1:0] exp_a;
    k = 0;
    done = 0;
    rst = 1; tick(); rst = 0; tick();
    i_req = 1; i_addr = 32'h100;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (mem_en) begin
        exp_a = (k % 3 == 2) ? 32'h100 : 32'h200;
        checks++;
        if (mem_addr !== exp_a) begin
          failures++;
          $display("FAIL streak_order grant=%0d got=%h exp=%h", k, mem_addr, exp_a);
        end
        k++;
      end
      if (i_ack && k == 6) done = 1;
      tick();
    end
    i_req = 0;
    d_req = 0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL streak_timeout grants=%0d exp=6", k);
    end
    tick();
  endtask

  task automatic test_store();
    poke(8'h18, 32'h55);
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin d_req = 1; d_we = 0; d_addr = 32'h60; end
      if (c == 5) d_req = 0;
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h55) begin
          failures++;
          $display("FAIL store_pre ack=%b data=%h exp 1/55", d_ack, d_rdata);
        end
      end
      tick();
    end
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin
        d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'h1234;
      end
      if (c == 5) begin d_req = 0; d_we = 0; end
      @(negedge clk);
      checks++;
      if (mem_en !== (c == 1) || mem_we !== (c == 1)) begin
        failures++;
        $display("FAIL store_en c=%0d en=%b we=%b", c, mem_en, mem_we);
      end
      if (c == 1) begin
        checks++;
        if (mem_addr !== 32'h8 || mem_wdata !== 32'h1234) begin
          failures++;
          $display("FAIL store_bus addr=%h wd=%h exp 8/1234", mem_addr, mem_wdata);
        end
      end
      checks++;
      if (d_ack !== (c == 4) || d_rdata !== 32'h55) begin
        failures++;
        $display("FAIL store_resp c=%0d ack=%b data=%h exp data=55", c, d_ack, d_rdata);
      end
      tick();
    end
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin d_req = 1; d_we = 0; d_addr = 32'h8; end
      if (c == 5) d_req = 0;
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h1234) begin
          failures++;
          $display("FAIL store_readback ack=%b data=%h exp 1/1234", d_ack, d_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_withdraw();
    poke(8'h11, 32'h600D_0044);
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin d_req = 1; d_we = 0; d_addr = 32'h44; end
      if (c == 1) begin d_req = 0; d_addr = 32'h48; end
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h44) begin
          failures++;
          $display("FAIL wd_issue en=%b addr=%h exp 1/44", mem_en, mem_addr);
        end
      end
      checks++;
      if (d_ack !== (c == 4)) begin
        failures++;
        $display("FAIL wd_ack c=%0d got=%b exp=%b", c, d_ack, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (d_rdata !== 32'h600D_0044) begin
          failures++;
          $display("FAIL wd_data got=%h exp=600d0044", d_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    d_req = 1; d_we = 0; d_addr = 32'h40;
    tick();
    tick();
    rst = 1;
    #1;
    checks++;
    if (mem_en !== 1'b0 || d_ack !== 1'b0 || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_async en=%b ack=%b data=%h exp 0/0/0", mem_en, d_ack, d_rdata);
    end
    d_req = 0;
    tick();
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (d_ack !== 1'b0 || mem_en !== 1'b0) begin
        failures++;
        $display("FAIL rst_noack c=%0d ack=%b en=%b exp 0/0", c, d_ack, mem_en);
      end
      tick();
    end
    for (int c = 0; c <= 5; c++) begin
      if (c == 0) begin i_req = 1; i_addr = 32'h10; end
      if (c == 5) i_req = 0;
      @(negedge clk);
      checks++;
      if (i_ack !== (c == 4)) begin
        failures++;
        $display("FAIL rst_refetch c=%0d got=%b exp=%b", c, i_ack, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (i_rdata !== 32'hDEAD_BEEF) begin
          failures++;
          $display("FAIL rst_refetch_data got=%h exp=deadbeef", i_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_lat1();
    poke(8'h01, 32'hCAFE_F00D);
    for (int c = 0; c <= 4; c++) begin
      if (c == 0) begin b_d_req = 1; b_d_we = 0; b_d_addr = 32'h4; end
      if (c == 4) b_d_req = 0;
      @(negedge clk);
      checks++;
      if (b_mem_en !== (c == 1)) begin
        failures++;
        $display("FAIL lat1_en c=%0d got=%b exp=%b", c, b_mem_en, (c == 1));
      end
      if (c == 1) begin
        checks++;
        if (b_mem_addr !== 32'h4) begin
          failures++;
          $display("FAIL lat1_addr got=%h exp=00000004", b_mem_addr);
        end
      end
      checks++;
      if (b_d_ack !== (c == 3)) begin
        failures++;
        $display("FAIL lat1_ack c=%0d got=%b exp=%b", c, b_d_ack, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (b_d_rdata !== 32'hCAFE_F00D) begin
          failures++;
          $display("FAIL lat1_data got=%h exp=cafef00d", b_d_rdata);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_streak();
    test_store();
    test_withdraw();
    test_reset_inflight();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
